// File: rtl/conv1x1_ctrl.sv
// Sequencer for a 1x1 convolution layer: walks pixels (outer) and output channels (inner),
// one PE operation at a time. Optional macro CONV1X1_CTRL_PERF_CNT_EN adds a busy-cycle counter.
module conv1x1_ctrl #(
  parameter int IN_CHANNEL = 4,
  parameter int PIX_W      = 16,
  parameter int OC_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PIX_W-1:0]      num_pixels,
  input  logic [OC_W-1:0]       num_oc,
  output logic                  busy,
  output logic                  done,
  output logic                  fm_rd_en,
  output logic [PIX_W-1:0]      fm_addr,
  output logic                  w_rd_en,
  output logic [OC_W-1:0]       w_addr,
  output logic                  pe_input_ready,
  input  logic                  pe_output_valid,
  input  logic [7:0]            pe_output_data,
  output logic                  out_wr_en,
  output logic [PIX_W+OC_W-1:0] out_addr,
  output logic [7:0]            out_data
`ifdef CONV1X1_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  localparam logic [PIX_W-1:0] PIX_ONE = 1;
  localparam logic [OC_W-1:0]  OC_ONE  = 1;

  // IN_CHANNEL sizes the PE operand path, which is routed outside this block.
  generate
    if (IN_CHANNEL < 1) begin : g_cfg_chk
      $error("conv1x1_ctrl: IN_CHANNEL must be at least 1");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [PIX_W-1:0]  np_r, p;
  logic [OC_W-1:0]   noc_r, o;
  logic              last_oc, last_pix, start_acc;

  assign start_acc = (state == S_IDLE) && start;
  assign last_oc   = (o == noc_r - OC_ONE);
  assign last_pix  = (p == np_r - PIX_ONE);
  assign fm_addr   = p;
  assign w_addr    = o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)
                 state_nxt = (num_pixels == '0 || num_oc == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (pe_output_valid) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (last_oc && last_pix) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    fm_rd_en       = 1'b0;
    w_rd_en        = 1'b0;
    pe_input_ready = 1'b0;
    out_wr_en      = 1'b0;
    case (state)
      S_FETCH: begin busy = 1'b1; fm_rd_en = 1'b1; w_rd_en = 1'b1; end
      S_ISSUE: begin busy = 1'b1; pe_input_ready = 1'b1; end
      S_WAIT:  busy = 1'b1;
      S_WRITE: begin busy = 1'b1; out_wr_en = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // out_addr tracks p*num_oc+o by increment alone; it is one bit per factor wide so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      np_r     <= '0;
      noc_r    <= '0;
      p        <= '0;
      o        <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (start_acc) begin
        np_r     <= num_pixels;
        noc_r    <= num_oc;
        p        <= '0;
        o        <= '0;
        out_addr <= '0;
      end
      if (state == S_WAIT && pe_output_valid)
        out_data <= pe_output_data;
      if (state == S_WRITE) begin
        out_addr <= out_addr + 1'b1;
        if (!last_oc) begin
          o <= o + OC_ONE;
        end else begin
          o <= '0;
          if (!last_pix) p <= p + PIX_ONE;
        end
      end
    end
  end

`ifdef CONV1X1_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cycle_cnt <= '0;
    else if (start_acc)                cycle_cnt <= '0;
    else if (busy && cycle_cnt != '1)  cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conv1x1_ctrl.sv
// Scoreboard bench for conv1x1_ctrl: stimulus queues expected reads/writes, a negedge monitor checks them.
module tb_conv1x1_ctrl;
  localparam int PIX_W = 16;
  localparam int OC_W  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [PIX_W-1:0]      num_pixels = '0;
  logic [OC_W-1:0]       num_oc = '0;
  logic                  busy, done, fm_rd_en, w_rd_en, pe_input_ready, out_wr_en;
  logic [PIX_W-1:0]      fm_addr;
  logic [OC_W-1:0]       w_addr;
  logic [PIX_W+OC_W-1:0] out_addr;
  logic [7:0]            out_data;
  logic                  pe_vld = 1'b0, spur_vld = 1'b0;
  logic [7:0]            pe_data = 8'd0;
  logic                  pe_output_valid;
`ifdef CONV1X1_CTRL_PERF_CNT_EN
  logic [31:0]           cycle_cnt;
`endif

  assign pe_output_valid = pe_vld | spur_vld;

  conv1x1_ctrl #(.IN_CHANNEL(4), .PIX_W(PIX_W), .OC_W(OC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pixels(num_pixels), .num_oc(num_oc),
    .busy(busy), .done(done), .fm_rd_en(fm_rd_en), .fm_addr(fm_addr),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .pe_input_ready(pe_input_ready),
    .pe_output_valid(pe_output_valid), .pe_output_data(pe_data),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data)
`ifdef CONV1X1_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int d; } pair_t;
  pair_t wq[$];
  pair_t rq[$];
  pair_t mon_e;

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, ready_cnt = 0, wr_cnt = 0, fetch_cnt = 0;
  int first_fetch_cyc = 0, done_cyc = 0, exp_cc = -1;
  bit busy_seen = 1'b0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void report_fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes a read or a write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (out_wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) report_fail("unexpected_write");
        else begin
          mon_e = wq.pop_front();
          check("out_addr", out_addr, mon_e.a);
          check("out_data", out_data, mon_e.d);
        end
      end
      if (fm_rd_en) begin
        fetch_cnt++;
        if (fetch_cnt == 1) first_fetch_cyc = cyc;
        check("w_rd_en_with_fm_rd_en", w_rd_en, 1);
        if (rq.size() == 0) report_fail("unexpected_fetch");
        else begin
          mon_e = rq.pop_front();
          check("fm_addr", fm_addr, mon_e.a);
          check("w_addr", w_addr, mon_e.d);
        end
      end
      if (pe_input_ready) ready_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
`ifdef CONV1X1_CTRL_PERF_CNT_EN
        if (exp_cc >= 0) check("cycle_cnt_at_done", cycle_cnt, exp_cc);
`endif
      end
      if ((fm_rd_en || out_wr_en || pe_input_ready) && !busy) report_fail("strobe_while_not_busy");
    end
  end

  // PE model: result appears lat+1 edges after the start pulse is sampled.
  int pe_lat = 3, pe_base = 0, pe_ops = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n && pe_input_ready) begin
      repeat (pe_lat + 1) @(posedge clk);
      #1;
      pe_data = 8'(pe_base + pe_ops);
      pe_vld  = 1'b1;
      pe_ops++;
      @(posedge clk);
      #1 pe_vld = 1'b0;
    end
  end

  // Spurious valid injected while the DUT is in FETCH, on the chosen fetch index.
  int spur_at = -1, spur_seen = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n && fm_rd_en) begin
      if (spur_seen == spur_at) begin
        spur_vld = 1'b1;
        @(posedge clk);
        #1 spur_vld = 1'b0;
      end
      spur_seen++;
    end
  end

  int s_cyc, d0, w0;

  task automatic launch(input int np, input int noc, input int lat, input int base, input int spur);
    pe_lat = lat; pe_base = base; pe_ops = 0; spur_at = spur; spur_seen = 0;
    for (int p = 0; p < np; p++)
      for (int o = 0; o < noc; o++) begin
        rq.push_back('{a: p, d: o});
        wq.push_back('{a: p * noc + o, d: (base + p * noc + o) % 256});
      end
    d0 = done_cnt; w0 = wr_cnt; fetch_cnt = 0; ready_cnt = 0; busy_seen = 1'b0;
    @(posedge clk); #1;
    num_pixels = PIX_W'(np); num_oc = OC_W'(noc); start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; num_pixels = '1; num_oc = '1;
  endtask

  task automatic run_pass(input int np, input int noc, input int lat, input int base,
                          input int spur, input bit restart, input int cc);
    exp_cc = cc;
    launch(np, noc, lat, base, spur);
    if (restart) begin
      for (int i = 0; i < 500 && ready_cnt < 2; i++) @(posedge clk);
      #1; num_pixels = 16'd7; num_oc = 8'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) report_fail("done_timeout");
    repeat (4) @(posedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("write_count", wr_cnt - w0, np * noc);
    check("pe_start_pulses", ready_cnt, np * noc);
    check("writes_outstanding", wq.size(), 0);
    check("fetches_outstanding", rq.size(), 0);
    wq.delete(); rq.delete();
    exp_cc = -1;
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fm_rd_en", fm_rd_en, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1x1, PE latency 3, result 5: done 7 cycles after FETCH entry, 7 busy cycles
    run_pass(1, 1, 3, 5, -1, 1'b0, 7);
    check("done_latency_1x1", done_cyc - first_fetch_cyc, 7);

    // 3x2 at latency 2: 6 elements of 6 busy cycles
    run_pass(3, 2, 2, 8'h10, -1, 1'b0, 36);

    // zero counts: straight to DONE, never busy
    run_pass(0, 4, 2, 0, -1, 1'b0, 0);
    check("zero_np_done_cycle", done_cyc - s_cyc, 1);
    check("zero_np_busy_seen", busy_seen, 0);
    run_pass(5, 0, 2, 0, -1, 1'b0, 0);
    check("zero_noc_done_cycle", done_cyc - s_cyc, 1);
    check("zero_noc_busy_seen", busy_seen, 0);

    // 3x2 again with a restart during WAIT and a spurious valid during the 2nd FETCH
    run_pass(3, 2, 2, 8'h20, 1, 1'b1, 36);

    // reset during the 3rd WAIT of a 2x2 pass
    launch(2, 2, 4, 8'h40, -1);
    for (int i = 0; i < 500 && ready_cnt < 3; i++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_fm_rd_en", fm_rd_en, 0);
    check("mid_rst_w_rd_en", w_rd_en, 0);
    check("mid_rst_pe_input_ready", pe_input_ready, 0);
    check("mid_rst_out_wr_en", out_wr_en, 0);
    check("mid_rst_fm_addr", fm_addr, 0);
    check("mid_rst_w_addr", w_addr, 0);
    check("mid_rst_out_addr", out_addr, 0);
    check("mid_rst_out_data", out_data, 0);
`ifdef CONV1X1_CTRL_PERF_CNT_EN
    check("mid_rst_cycle_cnt", cycle_cnt, 0);
`endif
    check("writes_before_reset", wr_cnt - w0, 2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", busy, 0);
    wq.delete(); rq.delete();

    run_pass(1, 1, 3, 8'h77, -1, 1'b0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit reached");
  end
endmodule
